// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one operand slice per stage,
// registered inter-slice carry, skewed operands and deskewed sum bits.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    cla_pipe_addsub_if.slave io
);
    localparam int W  = WIDTH / STAGES;
    localparam int NG = W / BLOCK;

    // Group carries ripple; inside a group every bit carry is a lookahead term.
    function automatic logic [W:0] slice_add(
        input logic [W-1:0] x,
        input logic [W-1:0] y,
        input logic         c0
    );
        logic [W-1:0] s;
        logic         cg;
        logic         gg;
        logic         pp;
        s  = '0;
        cg = c0;
        for (int g = 0; g < NG; g++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                s[g*BLOCK+i] = x[g*BLOCK+i] ^ y[g*BLOCK+i]
                             ^ (gg | (pp & cg));
                gg = (x[g*BLOCK+i] & y[g*BLOCK+i])
                   | ((x[g*BLOCK+i] ^ y[g*BLOCK+i]) & gg);
                pp = pp & (x[g*BLOCK+i] ^ y[g*BLOCK+i]);
            end
            cg = gg | (pp & cg);
        end
        return {cg, s};
    endfunction

    logic              adv;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic              zero_q;

    assign adv          = !v_q[STAGES-1] || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = v_q[STAGES-1];
    assign io.sum       = sum_q;
    assign io.cout      = cout_q;
    assign io.ovf       = ovf_q;
    assign io.zero      = zero_q;

    always_comb begin
        v_d = (v_q << 1) | STAGES'(io.in_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else if (adv) begin
            v_q <= v_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [W-1:0]       x;
        logic [W-1:0]       y;
        logic               ci;
        logic [W:0]         r;
        logic [(k+1)*W-1:0] acc;

        if (k == 0) begin : g_in
            assign x  = io.a[W-1:0];
            assign y  = io.sub ? ~io.b[W-1:0] : io.b[W-1:0];
            assign ci = io.sub | io.cin;
            assign acc = r[W-1:0];
        end else begin : g_in
            assign x  = g_st[k-1].g_mid.opa_q[W-1:0];
            assign y  = g_st[k-1].g_mid.opb_q[W-1:0];
            assign ci = g_st[k-1].g_mid.c_q;
            assign acc = {r[W-1:0], g_st[k-1].g_mid.res_q};
        end

        assign r = slice_add(x, y, ci);

        if (k < STAGES - 1) begin : g_mid
            localparam int RW = (STAGES - 1 - k) * W;
            logic [RW-1:0]      opa_q;
            logic [RW-1:0]      opb_q;
            logic [RW-1:0]      opa_d;
            logic [RW-1:0]      opb_d;
            logic [(k+1)*W-1:0] res_q;
            logic               c_q;

            // Operands for later slices travel along, b already conditioned.
            if (k == 0) begin : g_src
                assign opa_d = io.a[WIDTH-1:W];
                assign opb_d = io.sub ? ~io.b[WIDTH-1:W]
                                      : io.b[WIDTH-1:W];
            end else begin : g_src
                assign opa_d =
                    g_st[k-1].g_mid.opa_q[(STAGES-k)*W-1:W];
                assign opb_d =
                    g_st[k-1].g_mid.opb_q[(STAGES-k)*W-1:W];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                    res_q <= '0;
                    c_q   <= 1'b0;
                end else if (adv) begin
                    opa_q <= opa_d;
                    opb_q <= opb_d;
                    res_q <= acc;
                    c_q   <= r[W];
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] sum_d;
            logic             cout_d;
            logic             ovf_d;
            logic             zero_d;

            // Carry into the MSB recovered as P ^ S at that bit.
            assign sum_d  = acc;
            assign cout_d = r[W];
            assign ovf_d  = (x[W-1] ^ y[W-1] ^ r[W-1]) ^ r[W];
            assign zero_d = ~|acc;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: directed vectors, backpressure,
// and reset with beats in flight.
module tb_cla_pipe_addsub;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(WIDTH)) bus();

    cla_pipe_addsub #(
        .WIDTH (WIDTH),
        .BLOCK (4),
        .STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   sent   = 0;
    int   rcvd   = 0;
    logic stall_p = 1'b0;
    res_t held;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t cur();
        return {bus.sum, bus.cout, bus.ovf, bus.zero};
    endfunction

    task automatic mon_step();
        res_t e;
        if (rst) begin
            stall_p = 1'b0;
            return;
        end
        chk("in_ready", {31'd0, bus.in_ready},
            {31'd0, !(bus.out_valid && !bus.out_ready)});
        if (stall_p && bus.out_valid)
            chk("hold_stable", {13'd0, cur()}, {13'd0, held});
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected: got sum %h, none pending",
                         bus.sum);
            end else begin
                e = exp_q.pop_front();
                rcvd++;
                checks++;
                if (cur() !== e) begin
                    errors++;
                    $display("FAIL result: got sum=%h c=%b v=%b z=%b expected sum=%h c=%b v=%b z=%b",
                             bus.sum, bus.cout, bus.ovf, bus.zero,
                             e.sum, e.cout, e.ovf, e.zero);
                end
            end
        end
        stall_p = bus.out_valid && !bus.out_ready;
        held    = cur();
    endtask

    always @(negedge clk) mon_step();

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec,
                        input logic ev, input logic ez);
        logic ok;
        int   n;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        n            = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) begin
                exp_q.push_back({es, ec, ev, ez});
                sent++;
            end
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 expected 1");
        end
    endtask

    task automatic drain();
        int n;
        bus.in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, "_out_valid"}, {31'd0, bus.out_valid}, 0);
        chk({nm, "_sum"}, {16'd0, bus.sum}, 0);
        chk({nm, "_flags"}, {29'd0, bus.cout, bus.ovf, bus.zero}, 0);
        chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        chk_zero_outs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero_outs("post_reset");

        send(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0);
        send(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1);
        send(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0);
        send(16'h0003, 16'h0005, 0, 1, 16'hFFFE, 0, 0, 0);
        send(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0);
        send(16'h0005, 16'h0005, 1, 1, 16'h0000, 1, 0, 1);
        send(16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0, 0);
        send(16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFE, 1, 0, 0);
        send(16'h0080, 16'h0080, 0, 0, 16'h0100, 0, 0, 0);
        send(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1);
        send(16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0, 0);
        drain();

        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(16'(i), 16'(i), 0, 0, 16'(2 * i), 0, 0, 0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("beats_received", rcvd, sent);

        send(16'h0011, 16'h0022, 0, 0, 16'h0033, 0, 0, 0);
        send(16'h0044, 16'h0055, 0, 0, 16'h0099, 0, 0, 0);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_zero_outs("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("no_stale", {31'd0, bus.out_valid}, 0);
            @(posedge clk);
            #1;
        end

        send(16'h00F0, 16'h0010, 0, 0, 16'h0100, 0, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
